// File: rtl/lsu_ecc_scrub.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ecc_scrub
// Brief    : DCCM single-error write-back queue; re-encodes corrected words
//            and writes them back ahead of the store buffer.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ecc_scrub #(
    parameter int DCCM_BITS       = 16,
    parameter int DCCM_DATA_WIDTH = 32,
    parameter int DCCM_ECC_WIDTH  = 7,
    parameter int DEPTH           = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       single_ecc_error_lo_dc3,
    input  logic                       single_ecc_error_hi_dc3,
    input  logic [DCCM_BITS-1:0]       lsu_addr_dc3,
    input  logic [DCCM_BITS-1:0]       end_addr_dc3,
    input  logic [DCCM_DATA_WIDTH-1:0] sec_data_lo_dc3,
    input  logic [DCCM_DATA_WIDTH-1:0] sec_data_hi_dc3,
    input  logic                       dec_tlu_core_ecc_disable,
    input  logic                       scrub_wr_gnt,
    output logic                       scrub_wr_req,
    output logic [DCCM_BITS-1:0]       scrub_wr_addr,
    output logic [DCCM_DATA_WIDTH-1:0] scrub_wr_data,
    output logic [DCCM_ECC_WIDTH-1:0]  scrub_wr_ecc,
    output logic                       scrub_stbuf_block,
    output logic                       scrub_overflow,
    output logic [CNT_WIDTH-1:0]       scrub_corr_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int AW    = DCCM_BITS - 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    // Hamming SEC over non-power-of-two codeword positions, plus overall parity
    function automatic logic [DCCM_ECC_WIDTH-1:0] rvecc_encode(input logic [DCCM_DATA_WIDTH-1:0] din);
        logic [DCCM_ECC_WIDTH-1:0] ecc;
        int pos;
        ecc = '0;
        pos = 2;
        for (int i = 0; i < DCCM_DATA_WIDTH; i++) begin
            pos = pos + 1;
            if ((pos & (pos - 1)) == 0) pos = pos + 1;
            for (int k = 0; k < DCCM_ECC_WIDTH - 1; k++) begin
                if (pos[k]) ecc[k] = ecc[k] ^ din[i];
            end
        end
        ecc[DCCM_ECC_WIDTH-1] = (^din) ^ (^ecc[DCCM_ECC_WIDTH-2:0]);
        return ecc;
    endfunction

    logic [AW-1:0]              r_q_addr [DEPTH];
    logic [DCCM_DATA_WIDTH-1:0] r_q_data [DEPTH];
    logic [CW-1:0]              r_wr_ptr;
    logic [CW-1:0]              r_rd_ptr;
    logic [0:0]                 r_state;
    logic                       r_overflow;
    logic [CNT_WIDTH-1:0]       r_cnt;

    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_free;
    logic [CW-1:0]    w_count_nxt;
    logic             w_req;
    logic             w_pop;
    logic             w_push_lo;
    logic             w_push_hi;
    logic             w_lo_acc;
    logic             w_hi_acc;
    logic             w_drop;
    logic [PTR_W-1:0] w_lo_idx;
    logic [PTR_W-1:0] w_hi_idx;
    logic [PTR_W-1:0] w_rd_idx;

    assign w_req     = (r_state == REQ);
    assign w_pop     = w_req & scrub_wr_gnt;
    assign w_count   = r_wr_ptr - r_rd_ptr;
    // A same-cycle pop frees a slot for this cycle's push
    assign w_free    = c_depth - w_count + CW'(w_pop);
    assign w_push_lo = single_ecc_error_lo_dc3 & ~dec_tlu_core_ecc_disable;
    assign w_push_hi = single_ecc_error_hi_dc3 & ~dec_tlu_core_ecc_disable;
    assign w_lo_acc  = w_push_lo & (w_free != '0);
    assign w_hi_acc  = w_push_hi & (w_free > CW'(w_lo_acc));
    assign w_drop    = (w_push_lo & ~w_lo_acc) | (w_push_hi & ~w_hi_acc);
    assign w_lo_idx  = r_wr_ptr[PTR_W-1:0];
    assign w_hi_idx  = r_wr_ptr[PTR_W-1:0] + PTR_W'(w_lo_acc);
    assign w_rd_idx  = r_rd_ptr[PTR_W-1:0];
    assign w_count_nxt = w_count - CW'(w_pop) + CW'(w_lo_acc) + CW'(w_hi_acc);

    always_ff @(posedge clk) begin
        if (w_lo_acc) begin
            r_q_addr[w_lo_idx] <= lsu_addr_dc3[DCCM_BITS-1:2];
            r_q_data[w_lo_idx] <= sec_data_lo_dc3;
        end
        if (w_hi_acc) begin
            r_q_addr[w_hi_idx] <= end_addr_dc3[DCCM_BITS-1:2];
            r_q_data[w_hi_idx] <= sec_data_hi_dc3;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_state    <= IDLE;
            r_overflow <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + CW'(w_lo_acc) + CW'(w_hi_acc);
            r_rd_ptr   <= r_rd_ptr + CW'(w_pop);
            r_overflow <= w_drop;
            r_state    <= (w_count_nxt != '0) ? REQ : IDLE;
            if (w_pop && (r_cnt != {CNT_WIDTH{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign scrub_wr_req      = w_req;
    assign scrub_wr_addr     = w_req ? {r_q_addr[w_rd_idx], 2'b00} : '0;
    assign scrub_wr_data     = w_req ? r_q_data[w_rd_idx] : '0;
    assign scrub_wr_ecc      = rvecc_encode(scrub_wr_data);
    assign scrub_stbuf_block = (w_count != '0);
    assign scrub_overflow    = r_overflow;
    assign scrub_corr_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: doc/lsu_ecc_scrub.md
Name: lsu_ecc_scrub

Overview:
- DCCM single-error write-back unit, directly downstream of the LSU ECC decode stage.
- Captures the corrected (SEC) word and its address whenever a dc3 load/store reports a single-bit error on either DCCM bank.
- Queues those words and writes them back to the DCCM with freshly encoded ECC, so the latent error is scrubbed from memory.
- Arbitrates for the DCCM write port ahead of the store buffer and blocks stbuf drain while corrections are pending.

Parameters:
- DCCM_BITS, 16, DCCM byte-address width.
- DCCM_DATA_WIDTH, 32, bank data width.
- DCCM_ECC_WIDTH, 7, ECC bits per bank word.
- DEPTH, 2, correction queue entries (power of 2, >=2).
- CNT_WIDTH, 16, width of corrected-error counter.

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- single_ecc_error_lo_dc3  in  1  SEC on lo bank this cycle
- single_ecc_error_hi_dc3  in  1  SEC on hi bank this cycle
- lsu_addr_dc3  in  DCCM_BITS  start address (lo-bank word)
- end_addr_dc3  in  DCCM_BITS  end address (hi-bank word)
- sec_data_lo_dc3  in  DCCM_DATA_WIDTH  corrected lo-bank data
- sec_data_hi_dc3  in  DCCM_DATA_WIDTH  corrected hi-bank data
- dec_tlu_core_ecc_disable  in  1  suppresses new captures
- scrub_wr_gnt  in  1  DCCM write arbiter grant
- scrub_wr_req  out  1  DCCM write request
- scrub_wr_addr  out  DCCM_BITS  write address, [1:0]=0
- scrub_wr_data  out  DCCM_DATA_WIDTH  corrected data
- scrub_wr_ecc  out  DCCM_ECC_WIDTH  ECC of scrub_wr_data (rvecc_encode)
- scrub_stbuf_block  out  1  stall stbuf drain; high while any entry valid
- scrub_overflow  out  1  one-cycle pulse when a correction is dropped
- scrub_corr_cnt  out  CNT_WIDTH  saturating count of completed write-backs

Behaviour:
- Reset: queue empty, write/read pointers 0, FSM IDLE. All outputs 0: scrub_wr_req, scrub_wr_addr, scrub_wr_data, scrub_wr_ecc, scrub_stbuf_block, scrub_overflow, scrub_corr_cnt.
- Capture (cycle N):
  - Push lo when single_ecc_error_lo_dc3 & ~dec_tlu_core_ecc_disable. Entry = {lsu_addr_dc3[DCCM_BITS-1:2], sec_data_lo_dc3}.
  - Push hi likewise, using end_addr_dc3 and sec_data_hi_dc3.
  - Entry becomes visible at N+1.
- Dual push in one cycle: lo is written first, then hi. If only one slot is free, lo is kept, hi is dropped, and scrub_overflow pulses at N+1.
- Full queue: any push that finds no free slot is dropped, and scrub_overflow pulses at N+1 (single pulse even if both banks are dropped).
  - A pop in the same cycle frees one slot for that cycle's push.
- Duplicate address (same word already queued): a new entry is still pushed; both writes occur. No merge logic.
- FSM:
  - IDLE -> REQ when the queue is non-empty.
  - REQ: scrub_wr_req=1; addr/data/ECC are driven from the head entry and held stable until grant.
  - REQ & scrub_wr_gnt: pop at the clock edge and increment scrub_corr_cnt (saturates at all-ones).
  - After a pop: stay in REQ if entries remain (back-to-back writes allowed), else go to IDLE.
  - Grant is ignored outside REQ.
- Latency: an error at N gives scrub_wr_req at N+1 at the earliest; a grant at N+1 completes the write at N+1.
- scrub_wr_ecc: combinational from the head data through rvecc_encode.
- scrub_stbuf_block = queue non-empty (registered state, no combinational path from dc3 inputs).
- dec_tlu_core_ecc_disable asserted mid-operation: already-queued entries still drain; only new captures are suppressed.
- No flush input: corrections are kept even if the dc3 instruction is later killed, since the memory word is corrupt regardless.
- Reset mid-operation: queue discarded, request drops immediately (asynchronous).
- Pointer wrap is modulo DEPTH. Full/empty are distinguished by an extra pointer MSB.

Test Plan:
- Single lo error, lsu_addr_dc3=0x0104, sec_data_lo=0xDEADBEEF, gnt tied 1 -> at N+1: scrub_wr_req=1, scrub_wr_addr=0x0104, scrub_wr_data=0xDEADBEEF, ECC matches rvecc_encode; at N+2: req=0, scrub_corr_cnt=1, block=0.
- Dual error (lo 0x0104 / hi 0x0108), gnt held 0 for 3 cycles then 1 -> req stays high with addr 0x0104 stable; writes 0x0104 then 0x0108 on consecutive cycles; cnt=2.
- Queue full (DEPTH=2, gnt=0), third single error -> scrub_overflow pulses once; on release only the two original addresses are written.
- Full queue, gnt=1 and new lo error in the same cycle -> pop+push succeed, no overflow, entry count unchanged.
- dec_tlu_core_ecc_disable=1 with an error -> no capture, req stays 0; then set disable=1 while an entry is pending -> entry still written.
- rst_l asserted while req=1 and gnt=0 -> req, block and cnt go to 0 immediately; no write after reset release.
